eth_tx_scheduler: RTL and testbench

//  Sequences the Ethernet transmit engine in the eth_clk (50 MHz) domain.
//  Two requesters share the engine:
//   - a periodic game-state update, triggered once per video frame;
//   - a reset announcement, repeated several times.

---
 rtl/eth_tx_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_scheduler.sv
// Ethernet transmit sequencer: snapshots game state, arbitrates reset
// announcements, launches packets, enforces inter-frame gap and timeout.
// Optional statistics counters are built when TX_STATS_EN is defined.
module eth_tx_scheduler #(
  parameter int IFG_CYCLES     = 48,
  parameter int RST_REPEAT     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        eth_clk,
  input  logic        eth_rstn,
  input  logic        frame_tick,
  input  logic [33:0] state_in,
  input  logic        rst_req,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [43:0] tx_payload,
  output logic        rst_pending,
  output logic        tx_timeout
`ifdef TX_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
`endif
);

  localparam int CMAX = (TIMEOUT_CYCLES > IFG_CYCLES)
                        ? TIMEOUT_CYCLES : IFG_CYCLES;
  localparam int CW = $clog2(CMAX);
  localparam int RW = $clog2(RST_REPEAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    GAP
  } st_e;

  st_e         state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [2:0]  seq_q, seq_d;
  logic [33:0] shadow_q, shadow_d;
  logic        pend_q, pend_d;
  logic        is_rst_q, is_rst_d;
  logic        start_q, start_d;
  logic [43:0] payload_q, payload_d;
  logic        timeout_q, timeout_d;
  logic        launch_state;
  logic        done_ok;
  logic        tmo;
  logic        rst_pick;

  function automatic logic [43:0] build(
    input logic [33:0] s,
    input logic        r,
    input logic [2:0]  q
  );
    return {s[33:23], 1'b0, s[22:12], 1'b0,
            s[11:3], 3'b000, s[2:0], 1'b0, r, q};
  endfunction

  // Next-state logic: arbitration, launch, done/timeout, gap, snapshot
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rst_cnt_d    = rst_cnt_q;
    seq_d        = seq_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    is_rst_d     = is_rst_q;
    start_d      = 1'b0;
    payload_d    = payload_q;
    launch_state = 1'b0;
    done_ok      = 1'b0;
    tmo          = 1'b0;
    rst_pick     = (rst_cnt_q != '0);
    unique case (state_q)
      IDLE: begin
        if (!tx_busy && (rst_pick || pend_q)) begin
          start_d      = 1'b1;
          is_rst_d     = rst_pick;
          payload_d    = build(shadow_q, rst_pick, seq_q);
          seq_d        = seq_q + 3'd1;
          cnt_d        = '0;
          state_d      = WAIT_DONE;
          launch_state = !rst_pick;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          done_ok = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo     = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CW'(IFG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A tick in the launch cycle re-arms pend after the clear
    if (launch_state) pend_d = 1'b0;
    if (frame_tick) begin
      shadow_d = state_in;
      pend_d   = 1'b1;
    end
    if (done_ok && is_rst_q && rst_pick)
      rst_cnt_d = rst_cnt_q - 1'b1;
    if (rst_req) rst_cnt_d = RW'(RST_REPEAT);
    timeout_d = timeout_q | tmo;
  end

  // State and datapath registers
  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rst_cnt_q <= '0;
      seq_q     <= '0;
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      is_rst_q  <= 1'b0;
      start_q   <= 1'b0;
      payload_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_cnt_q <= rst_cnt_d;
      seq_q     <= seq_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      is_rst_q  <= is_rst_d;
      start_q   <= start_d;
      payload_q <= payload_d;
      timeout_q <= timeout_d;
    end
  end

  assign tx_start    = start_q;
  assign tx_payload  = payload_q;
  assign rst_pending = (rst_cnt_q != '0);
  assign tx_timeout  = timeout_q;

`ifdef TX_STATS_EN
  logic [15:0] pkt_q, pkt_d;
  logic [15:0] drop_q, drop_d;
  logic        drop;
  logic [16:0] dsum;

  // Saturating packet and drop counters
  always_comb begin
    drop  = frame_tick && pend_q && !launch_state;
    pkt_d = pkt_q;
    if (done_ok && pkt_q != 16'hFFFF) pkt_d = pkt_q + 16'd1;
    dsum  = {1'b0, drop_q} + {16'd0, drop} + {16'd0, tmo};
    drop_d = dsum[16] ? 16'hFFFF : dsum[15:0];
  end

  // Statistics registers
  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      drop_q <= drop_d;
    end
  end

  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed + randomized bench for eth_tx_scheduler with a field-level
// payload model, an engine responder and a start monitor.
module tb_eth_tx_scheduler;

  logic        clk = 1'b0;
  logic        eth_rstn;
  logic        frame_tick;
  logic [33:0] state_in;
  logic        rst_req;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_start;
  logic [43:0] tx_payload;
  logic        rst_pending;
  logic        tx_timeout;
`ifdef TX_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
`endif

  eth_tx_scheduler dut (
    .eth_clk    (clk),
    .eth_rstn   (eth_rstn),
    .frame_tick (frame_tick),
    .state_in   (state_in),
    .rst_req    (rst_req),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_start   (tx_start),
    .tx_payload (tx_payload),
    .rst_pending(rst_pending),
    .tx_timeout (tx_timeout)
`ifdef TX_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
`endif
  );

  always #10 clk = ~clk;

  int cyc = 0;
  int n_starts = 0;
  int n_dones = 0;
  int last_done = -1000;
  int vectors = 0;
  int miscompares = 0;
  bit respond = 1'b1;
  int done_dly = 20;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_start === 1'b1) n_starts <= n_starts + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [43:0] mk(input logic [33:0] s,
                                     input logic r,
                                     input logic [2:0] q);
    logic [10:0] x, y;
    logic [8:0]  d;
    logic [2:0]  g;
    {x, y, d, g} = s;
    mk = '0;
    mk[43:33] = x;
    mk[31:21] = y;
    mk[19:11] = d;
    mk[7:5]   = g;
    mk[3]     = r;
    mk[2:0]   = q;
  endfunction

  // Engine model: pulses tx_done done_dly cycles after each start
  initial begin
    tx_done = 1'b0;
    forever begin
      step();
      tx_done = 1'b0;
      if (tx_start === 1'b1 && respond) begin
        repeat (done_dly) step();
        tx_done = 1'b1;
        last_done = cyc;
        n_dones++;
      end
    end
  end

  task automatic wait_start(input string tag, input int budget,
                            output logic [43:0] pl);
    int n = 0;
    while (tx_start !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, tx_start, 1'b1);
    pl = tx_payload;
    if (tx_start === 1'b1)
      check("ifg", 64'(cyc - last_done >= 49), 1'b1);
    step();
  endtask

  task automatic pulse_tick(input logic [33:0] s);
    state_in   = s;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  int pkt_base = 0;
  int exp_drop = 0;

  task automatic do_reset();
    eth_rstn = 1'b0;
    step();
    step();
    eth_rstn = 1'b1;
    pkt_base = n_dones;
    exp_drop = 0;
    step();
  endtask

  task automatic check_stats(input string tag);
`ifdef TX_STATS_EN
    check({tag, "_pkt"}, pkt_count, 64'(n_dones - pkt_base));
    check({tag, "_drop"}, drop_count, 64'(exp_drop));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  logic [33:0] st, st2, last_st;
  logic [43:0] pl, exp_pl;
  logic [2:0]  eseq;
  int          ns;

  initial begin
    eth_rstn = 1'b0; frame_tick = 1'b0; state_in = '0;
    rst_req = 1'b0; tx_busy = 1'b0;
    repeat (3) step();
    check("rst_start", tx_start, 1'b0);
    check("rst_payload", tx_payload, 44'd0);
    check("rst_pending0", rst_pending, 1'b0);
    check("rst_timeout", tx_timeout, 1'b0);
    eth_rstn = 1'b1;
    step();
    eseq = 3'd0;

    // T1: fixed snapshot, exact two-cycle latency
    st = {11'd191, 11'd191, 9'd270, 3'd1};
    pulse_tick(st);
    check("t1_lat_early", tx_start, 1'b0);
    step();
    check("t1_start", tx_start, 1'b1);
    exp_pl = mk(st, 1'b0, eseq);
    check("t1_payload", tx_payload, exp_pl);
    eseq++;
    repeat (30) step();
    check("t1_hold", tx_payload, exp_pl);
    repeat (60) step();
    check("t1_single", tx_start, 1'b0);

    // Randomized snapshots and engine latencies
    for (int i = 0; i < 6; i++) begin
      st = 34'({$urandom(), $urandom()});
      done_dly = $urandom_range(1, 30);
      pulse_tick(st);
      wait_start("t1r_start", 10, pl);
      check("t1r_payload", pl, mk(st, 1'b0, eseq));
      eseq++;
      repeat (done_dly + 60) step();
    end
    done_dly = 20;

    // Tick landing on the launch edge: old shadow goes, new one re-arms
    st  = 34'({$urandom(), $urandom()});
    st2 = 34'({$urandom(), $urandom()});
    state_in = st; frame_tick = 1'b1;
    step();
    state_in = st2;
    step();
    frame_tick = 1'b0;
    wait_start("sim_start", 0, pl);
    check("sim_old", pl, mk(st, 1'b0, eseq));
    eseq++;
    wait_start("sim_start2", 200, pl);
    check("sim_new", pl, mk(st2, 1'b0, eseq));
    eseq++;
    last_st = st2;
    repeat (90) step();
    check_stats("sim");

    // T2: reset announcement burst
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    check("t2_pending", rst_pending, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_start("t2_start", 200, pl);
      check("t2_payload", pl, mk(last_st, 1'b1, eseq));
      eseq++;
    end
    repeat (100) step();
    ns = n_starts;
    check("t2_pending_clr", rst_pending, 1'b0);
    repeat (200) step();
    check("t2_no_extra", 64'(n_starts - ns), 64'd0);
    check_stats("t2");

    // T3: reset request and tick together, from a fresh reset
    do_reset();
    eseq = 3'd0;
    st = 34'({$urandom(), $urandom()});
    state_in = st; rst_req = 1'b1; frame_tick = 1'b1;
    step();
    rst_req = 1'b0; frame_tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_start("t3_start", 200, pl);
      check("t3_payload", pl, mk(st, k < 4, eseq));
      eseq++;
    end
    repeat (100) step();
    check_stats("t3");

    // T4: two ticks while engine busy -> newest snapshot only
    tx_busy = 1'b1;
    ns = n_starts;
    st  = 34'({$urandom(), $urandom()});
    st2 = 34'({$urandom(), $urandom()});
    pulse_tick(st);
    repeat (5) step();
    pulse_tick(st2);
    exp_drop++;
    repeat (5) step();
    check("t4_held", 64'(n_starts - ns), 64'd0);
    tx_busy = 1'b0;
    wait_start("t4_start", 10, pl);
    check("t4_payload", pl, mk(st2, 1'b0, eseq));
    eseq++;
    repeat (100) step();
    check("t4_once", 64'(n_starts - ns), 64'd1);
    check_stats("t4");

    // T5: withheld done -> timeout; STATE abandoned, RESET retried
    respond = 1'b0;
    st = 34'({$urandom(), $urandom()});
    pulse_tick(st);
    wait_start("t5_start", 10, pl);
    check("t5_payload", pl, mk(st, 1'b0, eseq));
    eseq++;
    repeat (4085) step();
    check("t5_not_yet", tx_timeout, 1'b0);
    for (int n = 0; n < 30 && tx_timeout !== 1'b1; n++) step();
    check("t5_timeout", tx_timeout, 1'b1);
    exp_drop++;
    ns = n_starts;
    repeat (300) step();
    check("t5_no_resend", 64'(n_starts - ns), 64'd0);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    wait_start("t5_rst_start", 20, pl);
    check("t5_rst_payload", pl, mk(st, 1'b1, eseq));
    eseq++;
    respond = 1'b1;
    wait_start("t5_retry", 4300, pl);
    check("t5_retry_payload", pl, mk(st, 1'b1, eseq));
    eseq++;
    exp_drop++;
    for (int k = 0; k < 3; k++) begin
      wait_start("t5_rest", 200, pl);
      check("t5_rest_payload", pl, mk(st, 1'b1, eseq));
      eseq++;
    end
    repeat (100) step();
    check("t5_pending_clr", rst_pending, 1'b0);
    check("t5_sticky", tx_timeout, 1'b1);
    check_stats("t5");

    // T6: asynchronous reset while waiting for done
    respond = 1'b0;
    st = 34'({$urandom(), $urandom()});
    pulse_tick(st);
    wait_start("t6_start", 10, pl);
    check("t6_payload", pl, mk(st, 1'b0, eseq));
    repeat (5) step();
    #3 eth_rstn = 1'b0;
    #1;
    check("t6_async_payload", tx_payload, 44'd0);
    check("t6_async_start", tx_start, 1'b0);
    check("t6_async_pending", rst_pending, 1'b0);
    check("t6_async_timeout", tx_timeout, 1'b0);
    step();
    step();
    eth_rstn = 1'b1;
    pkt_base = n_dones;
    exp_drop = 0;
    respond = 1'b1;
    step();
    eseq = 3'd0;
    st2 = 34'({$urandom(), $urandom()});
    pulse_tick(st2);
    wait_start("t6_restart", 10, pl);
    check("t6_restart_payload", pl, mk(st2, 1'b0, eseq));
    repeat (100) step();
    check("t6_timeout_clr", tx_timeout, 1'b0);
    check_stats("t6");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
